// File: rtl/masked_and_seq.sv
// masked_and_seq
//   Bit-serial sequencer around a single 2-share DOM-style masked AND gadget.
//   Two W-bit Boolean-shared operands are accepted over a valid/ready handshake.
//   One bit pair is issued per cycle, LSB first, together with a fresh mask bit.
//   The gadget output shares are gathered into W-bit result registers, and the
//   result is presented over a second valid/ready handshake.
//
//   Build option: MASKMYBIT_LFSR_EN
//     defined   - an internal 16-bit Galois LFSR supplies the mask and the rnd
//                 port is absent.
//     undefined - the mask is taken from rnd in each issue cycle.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   a0,a1,b0,b1        operand shares, A = a0^a1, B = b0^b1
//   rnd                external fresh mask bit (only without MASKMYBIT_LFSR_EN)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   x0,x1              result shares, x0^x1 = A&B
//   busy               high in RUN, DRAIN and DONE

// 2-share DOM-indep AND: four partial products, with the two cross terms
// remasked by r before the register stage. Output latency is one cycle.
module masked_and_dom (
    input  logic clk,
    input  logic rstn,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic r,
    output logic x0,
    output logic x1
);
    logic p00_q, p01_q, p10_q, p11_q;
    logic p00_d, p01_d, p10_d, p11_d;

    always_comb begin
        p00_d = a0 & b0;
        p01_d = (a0 & b1) ^ r;
        p10_d = (a1 & b0) ^ r;
        p11_d = a1 & b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p00_q <= 1'b0;
            p01_q <= 1'b0;
            p10_q <= 1'b0;
            p11_q <= 1'b0;
        end else begin
            p00_q <= p00_d;
            p01_q <= p01_d;
            p10_q <= p10_d;
            p11_q <= p11_d;
        end
    end

    // The two shares are recombined only after the register stage, so that
    // glitches cannot combine the cross terms before they are remasked.
    assign x0 = p00_q ^ p01_q;
    assign x1 = p11_q ^ p10_q;
endmodule

module masked_and_seq #(
    parameter int          W    = 8,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
`ifndef MASKMYBIT_LFSR_EN
    input  logic         rnd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic         busy
);
    localparam int          IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  opa0_q, opa1_q, opb0_q, opb1_q;
    logic [W-1:0]  opa0_d, opa1_d, opb0_d, opb1_d;
    logic [W-1:0]  x0_q, x1_q, x0_d, x1_d;
    // Tag of the bit issued last cycle; its gadget output is captured now.
    logic          cap_vld_q, cap_vld_d;
    logic [IW-1:0] cap_idx_q, cap_idx_d;

    logic in_hs, out_hs, issue, last_bit;
    logic gad_a0, gad_a1, gad_b0, gad_b1, gad_r, gad_x0, gad_x1;
    logic mask_bit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_bit)  state_d = S_DRAIN;
            S_DRAIN:                state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        issue     = (state_q == S_RUN);
    end

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign last_bit = (idx_q == IW'(W - 1));

    // ---------------- mask source ----------------
`ifdef MASKMYBIT_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1; advances only on issue cycles.
    always_comb begin
        lfsr_d = lfsr_q;
        if (issue)
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr_q <= SEED_EFF;
        else       lfsr_q <= lfsr_d;
    end

    assign mask_bit = lfsr_q[0];
`else
    // The seed only matters when the internal LFSR is built.
    logic unused_seed;
    assign unused_seed = ^SEED_EFF;
    assign mask_bit    = rnd;
`endif

    // Gadget inputs are forced to 0 outside issue cycles, so stale shares
    // never toggle the gadget.
    always_comb begin
        gad_a0 = issue & opa0_q[idx_q];
        gad_a1 = issue & opa1_q[idx_q];
        gad_b0 = issue & opb0_q[idx_q];
        gad_b1 = issue & opb1_q[idx_q];
        gad_r  = issue & mask_bit;
    end

    masked_and_dom u_gadget (
        .clk  (clk),
        .rstn (rstn),
        .a0   (gad_a0),
        .a1   (gad_a1),
        .b0   (gad_b0),
        .b1   (gad_b1),
        .r    (gad_r),
        .x0   (gad_x0),
        .x1   (gad_x1)
    );

    // ---------------- datapath ----------------
    always_comb begin
        idx_d     = idx_q;
        opa0_d    = opa0_q;
        opa1_d    = opa1_q;
        opb0_d    = opb0_q;
        opb1_d    = opb1_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        cap_vld_d = issue;
        cap_idx_d = idx_q;

        if (in_hs) begin
            opa0_d = a0;
            opa1_d = a1;
            opb0_d = b0;
            opb1_d = b1;
            idx_d  = '0;
        end

        if (issue)
            idx_d = last_bit ? '0 : idx_q + IW'(1);

        if (cap_vld_q) begin
            x0_d[cap_idx_q] = gad_x0;
            x1_d[cap_idx_q] = gad_x1;
        end

        // Zeroize shares once the result has been consumed.
        if (out_hs) begin
            opa0_d = '0;
            opa1_d = '0;
            opb0_d = '0;
            opb1_d = '0;
            x0_d   = '0;
            x1_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q     <= '0;
            opa0_q    <= '0;
            opa1_q    <= '0;
            opb0_q    <= '0;
            opb1_q    <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            opa0_q    <= opa0_d;
            opa1_q    <= opa1_d;
            opb0_q    <= opb0_d;
            opb1_q    <= opb1_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign x0 = x0_q;
    assign x1 = x1_q;
endmodule

// File: tb/tb_masked_and_seq.sv
// Testbench for masked_and_seq (W=8). A cycle-level reference model tracks
// the operation phase and the mask bits consumed, and derives the result
// shares as x0 = (a0 & B) ^ r, x1 = (a1 & B) ^ r. One compare process checks
// the DUT against that model on every falling edge; directed runs add
// hand-computed literal expectations.
module tb_masked_and_seq;
    localparam int          W    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         rnd = 1'b0;
    logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] x0, x1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    masked_and_seq #(.W(W), .SEED(SEED)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
`ifndef MASKMYBIT_LFSR_EN
        .rnd       (rnd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .x1        (x1),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_active = 1'b0;
    int           m_t = 0;          // cycle number since the input handshake
    logic [W-1:0] m_a0 = '0, m_a1 = '0, m_b0 = '0, m_b1 = '0;
    logic [W-1:0] m_r = '0;         // mask bit used for each result bit
    logic [15:0]  m_lfsr = SEED;
    logic         m_mask;

`ifdef MASKMYBIT_LFSR_EN
    assign m_mask = m_lfsr[0];
`else
    assign m_mask = rnd;
`endif

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_lfsr   <= SEED;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_t      <= 1;
                m_a0     <= a0;
                m_a1     <= a1;
                m_b0     <= b0;
                m_b1     <= b1;
            end
        end else begin
            if (m_t >= 1 && m_t <= W) begin
                m_r[m_t-1] <= m_mask;
                m_lfsr     <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            end
            if (m_t >= W + 2 && out_ready) m_active <= 1'b0;
            else                           m_t      <= m_t + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rstn) begin
            logic         exp_ov, iss;
            logic [W-1:0] bb;
            exp_ov = m_active && (m_t >= W + 2);
            iss    = m_active && (m_t >= 1) && (m_t <= W);
            bb     = m_b0 ^ m_b1;
            chk("in_ready",  64'(in_ready),  64'(!m_active));
            chk("busy",      64'(busy),      64'(m_active));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (iss) begin
                chk("gad_a0", 64'(dut.gad_a0), 64'(m_a0[m_t-1]));
                chk("gad_a1", 64'(dut.gad_a1), 64'(m_a1[m_t-1]));
                chk("gad_b0", 64'(dut.gad_b0), 64'(m_b0[m_t-1]));
                chk("gad_b1", 64'(dut.gad_b1), 64'(m_b1[m_t-1]));
                chk("gad_r",  64'(dut.gad_r),  64'(m_mask));
            end else begin
                chk("gad_idle", 64'({dut.gad_a0, dut.gad_a1, dut.gad_b0, dut.gad_b1, dut.gad_r}), 64'd0);
            end
            if (exp_ov) begin
                chk("x0", 64'(x0), 64'((m_a0 & bb) ^ m_r));
                chk("x1", 64'(x1), 64'((m_a1 & bb) ^ m_r));
                chk("x_and", 64'(x0 ^ x1), 64'((m_a0 ^ m_a1) & bb));
            end else if (!m_active) begin
                chk("x_idle", 64'({x0, x1}), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Runs one operation starting in the current cycle (cycle 0). rpat[k] is
    // the rnd value driven during the issue of bit k. stall = number of DONE
    // cycles with out_ready low; in_valid is pushed during the stall.
    task automatic run_op(input logic [W-1:0] ia0, input logic [W-1:0] ia1,
                          input logic [W-1:0] ib0, input logic [W-1:0] ib1,
                          input logic [W-1:0] rpat, input int stall,
                          output logic [W-1:0] rx0, output logic [W-1:0] rx1,
                          output int lat);
        bit hs;
        a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        rnd       = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; hs = 1'b0; rx0 = '0; rx1 = '0;
        for (int cyc = 1; cyc < 60 && !hs; cyc++) begin
            rnd = (cyc <= W) ? rpat[cyc-1] : 1'b0;
            if (lat >= 0) begin
                out_ready = (stall == 0) || (cyc >= lat + stall);
                in_valid  = (cyc < lat + stall);
                if (in_valid) begin
                    a0 = W'($urandom); a1 = W'($urandom);
                    b0 = W'($urandom); b1 = W'($urandom);
                end
            end
            @(negedge clk);
            if (out_valid && lat < 0) begin
                lat = cyc; rx0 = x0; rx1 = x1;
            end
            if (out_valid && out_ready) hs = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rnd      = 1'b0;
        chk("op_complete", 64'(hs), 64'd1);
    endtask

    initial begin
        logic [W-1:0] x0a, x1a, x0b, x1b, x0z1, x1z1, x0z2, x1z2, x0s, x1s, x0c, x1c;
        int lat;

        // reset state
        #2;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_x",         64'({x0, x1}),  64'd0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // basic: A=0xA5, B=0x0F, A&B=0x05; rnd alternates 1,0 (r=0x55)
        run_op(8'h3C, 8'h99, 8'h55, 8'h5A, 8'h55, 0, x0a, x1a, lat);
        chk("lat_basic", 64'(lat), 64'd10);
        chk("and_basic", 64'(x0a ^ x1a), 64'h05);
`ifndef MASKMYBIT_LFSR_EN
        chk("x0_basic", 64'(x0a), 64'h59);
        chk("x1_basic", 64'(x1a), 64'h5C);
`endif

        // same operands, rnd held at 0
        run_op(8'h3C, 8'h99, 8'h55, 8'h5A, 8'h00, 0, x0b, x1b, lat);
        chk("and_rnd0", 64'(x0b ^ x1b), 64'h05);
`ifndef MASKMYBIT_LFSR_EN
        chk("x0_rnd0",      64'(x0b),       64'h0C);
        chk("x0_diff_rnd",  64'(x0a ^ x0b), 64'h55);
`endif

        // zero operand B: x0 carries only the mask
        run_op(8'hF0, 8'h0F, 8'hC3, 8'hC3, 8'hA5, 0, x0z1, x1z1, lat);
        run_op(8'hF0, 8'h0F, 8'hC3, 8'hC3, 8'h3C, 0, x0z2, x1z2, lat);
        chk("and_zero1", 64'(x0z1 ^ x1z1), 64'h00);
        chk("and_zero2", 64'(x0z2 ^ x1z2), 64'h00);
        chk("zero_x0_varies", 64'(x0z1 != x0z2), 64'd1);
`ifndef MASKMYBIT_LFSR_EN
        chk("x0_zero1", 64'(x0z1), 64'hA5);
`endif

        // output stall of 5 cycles with in_valid pushed meanwhile:
        // A=0x26, B=0xF0, A&B=0x20
        run_op(8'h12, 8'h34, 8'hFF, 8'h0F, 8'hC3, 5, x0s, x1s, lat);
        chk("lat_stall", 64'(lat), 64'd10);
        chk("and_stall", 64'(x0s ^ x1s), 64'h20);

        // reset in cycle 4 (fourth RUN cycle)
        a0 = 8'hFF; a1 = 8'h00; b0 = 8'hFF; b1 = 8'h00;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy",      64'(busy),      64'd0);
        chk("mid_rst_x",         64'({x0, x1}),  64'd0);
        chk("mid_rst_gad", 64'({dut.gad_a0, dut.gad_a1, dut.gad_b0, dut.gad_b1, dut.gad_r}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // first operation after reset repeats the very first one exactly
        // (mask source restarted from SEED, same rnd pattern)
        run_op(8'h3C, 8'h99, 8'h55, 8'h5A, 8'h55, 0, x0c, x1c, lat);
        chk("and_after_rst", 64'(x0c ^ x1c), 64'h05);
        chk("x0_after_rst",  64'(x0c), 64'(x0a));
        chk("x1_after_rst",  64'(x1c), 64'(x1a));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
